// File: rtl/ack_pkg.sv
// ack_pkg: shared response entry type and queue sizing limits
package ack_pkg;
  localparam int ACK_DEPTH_MIN = 2;
  localparam int ACK_DEPTH_MAX = 16;
  localparam int ACK_WID_MAX   = 16;
  localparam int ACK_DWID_MAX  = 64;

  typedef struct packed {
    logic                    we;
    logic [ACK_WID_MAX-1:0]  id;
    logic [ACK_DWID_MAX-1:0] dat;
  } resp_t;

  function automatic resp_t mk_resp(logic we, logic [ACK_WID_MAX-1:0] id, logic [ACK_DWID_MAX-1:0] dat);
    resp_t r;
    r.we  = we;
    r.id  = id;
    r.dat = dat;
    return r;
  endfunction
endpackage

// File: rtl/ack_resp_ram.sv
// ack_resp_ram: entry storage with two adjacent write ports and one async read port
module ack_resp_ram
  import ack_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wptr,
  input  resp_t         d0,
  input  resp_t         d1,
  input  logic [AW-1:0] rptr,
  output resp_t         rd
);
  resp_t mem [DEPTH];

  // wr0 lands at wptr, wr1 at the following slot (wraps with the pointer width)
  always_ff @(posedge clk) begin
    if (we0) mem[wptr] <= d0;
    if (we1) mem[wptr + AW'(1)] <= d1;
  end

  assign rd = mem[rptr];
endmodule

// File: rtl/ack_resp_queue.sv
// ack_resp_queue: merges read/write ack events into one ordered response FIFO
module ack_resp_queue
  import ack_pkg::*;
#(
  parameter int WID   = 6,
  parameter int DWID  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ce_i,
  input  logic                     rack_i,
  input  logic [WID-1:0]           rid_i,
  input  logic [DWID-1:0]          rdat_i,
  input  logic                     wack_i,
  input  logic [WID-1:0]           wid_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic                     resp_we_o,
  output logic [WID-1:0]           resp_id_o,
  output logic [DWID-1:0]          resp_dat_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, free;
  logic [1:0]    n_acc;
  logic          ovf, deq, ev_w, ev_r, acc_w, acc_r, drop;
  resp_t         w_ent, r_ent, head;
  logic          unused_head;

  // Qualify events, size the free space (a same-edge dequeue frees a slot) and favour the write entry
  always_comb begin
    ev_w  = ce_i & wack_i;
    ev_r  = ce_i & rack_i;
    deq   = (count != '0) & resp_ready_i;
    free  = CW'(DEPTH) - count + CW'(deq);
    acc_w = ev_w & (free != '0);
    acc_r = ev_r & (free >= (ev_w ? CW'(2) : CW'(1)));
    drop  = (ev_w & ~acc_w) | (ev_r & ~acc_r);
    n_acc = {1'b0, acc_w} + {1'b0, acc_r};
    w_ent = mk_resp(1'b1, ACK_WID_MAX'(wid_i), '0);
    r_ent = mk_resp(1'b0, ACK_WID_MAX'(rid_i), ACK_DWID_MAX'(rdat_i));
  end

  ack_resp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk  (clk_i),
    .we0  (acc_w | acc_r),
    .we1  (acc_w & acc_r),
    .wptr (wptr),
    .d0   (acc_w ? w_ent : r_ent),
    .d1   (r_ent),
    .rptr (rptr),
    .rd   (head)
  );

  // Pointers wrap naturally at the power-of-two depth; overflow is sticky until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      wptr  <= wptr + AW'(n_acc);
      rptr  <= rptr + AW'(deq);
      count <= count + CW'(n_acc) - CW'(deq);
      ovf   <= ovf | drop;
    end
  end

  assign resp_valid_o = count != '0;
  assign resp_we_o    = resp_valid_o & head.we;
  assign resp_id_o    = resp_valid_o ? head.id[WID-1:0] : '0;
  assign resp_dat_o   = resp_valid_o ? head.dat[DWID-1:0] : '0;
  assign count_o      = count;
  assign full_o       = count == CW'(DEPTH);
  assign empty_o      = count == '0;
  assign ovf_o        = ovf;
  assign unused_head  = ^head;
endmodule
